// File: rtl/floo_isol_pkg.sv
// Shared types and width helpers for the tile port isolator.
package floo_isol_pkg;

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2,
        TIMEOUT  = 2'd3
    } isol_state_e;

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

    // Floor at one bit so tiny timeouts still yield a legal vector.
    function automatic int tmr_width(input int drain_timeout);
        return (drain_timeout > 2) ? $clog2(drain_timeout) : 1;
    endfunction

endpackage

// File: rtl/floo_isol_port_ctrl.sv
// Purpose: single-port isolation FSM, outstanding/burst tracking and valid/ready gating.
// Latency: zero-cycle combinational pass-through; ack/timeout/stray are registered.
// Backpressure: requests held off at the outstanding limit or while draining/fenced; fenced responses are sunk.
module floo_isol_port_ctrl
    import floo_isol_pkg::*;
#(
    parameter int ReqWidth       = 64,
    parameter int RspWidth       = 64,
    parameter int MaxOutstanding = 16,
    parameter int DrainTimeout   = 1024,
    localparam int CntWidth      = cnt_width(MaxOutstanding)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                isol_req_i,
    output logic                isol_ack_o,
    output logic                timeout_o,
    output logic                stray_rsp_o,
    input  logic                tile_req_valid_i,
    output logic                tile_req_ready_o,
    input  logic                tile_req_last_i,
    input  logic [ReqWidth-1:0] tile_req_data_i,
    output logic                link_req_valid_o,
    input  logic                link_req_ready_i,
    output logic                link_req_last_o,
    output logic [ReqWidth-1:0] link_req_data_o,
    input  logic                link_rsp_valid_i,
    output logic                link_rsp_ready_o,
    input  logic [RspWidth-1:0] link_rsp_data_i,
    output logic                tile_rsp_valid_o,
    input  logic                tile_rsp_ready_i,
    output logic [RspWidth-1:0] tile_rsp_data_o,
    output logic [CntWidth-1:0] outstanding_o
);

    localparam int TmrWidth = tmr_width(DrainTimeout);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(DrainTimeout - 1);

    isol_state_e          state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [TmrWidth-1:0]  tmr_q, tmr_d;
    logic                 burst_q, burst_d;
    logic                 ack_q, timeout_q, stray_q, stray_d;
    logic                 gated, req_block;
    logic                 req_hs, rsp_hs, cnt_inc, cnt_dec;

    // An open burst always finishes; only a fresh request can be held off.
    always_comb begin
        gated     = (state_q == ISOLATED) || (state_q == TIMEOUT);
        req_block = gated || (!burst_q && ((state_q == DRAIN) || (cnt_q == CntMax)));
    end

    assign link_req_valid_o = tile_req_valid_i & ~req_block;
    assign tile_req_ready_o = link_req_ready_i & ~req_block;
    assign link_req_last_o  = tile_req_last_i;
    assign link_req_data_o  = tile_req_data_i;

    assign tile_rsp_valid_o = link_rsp_valid_i & ~gated;
    assign link_rsp_ready_o = gated | tile_rsp_ready_i;
    assign tile_rsp_data_o  = link_rsp_data_i;

    assign req_hs  = link_req_valid_o & link_req_ready_i;
    assign rsp_hs  = link_rsp_valid_i & link_rsp_ready_o;
    assign cnt_inc = req_hs & tile_req_last_i;
    assign cnt_dec = rsp_hs & ~gated;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        burst_d = burst_q;
        // Dropped responses and responses with nothing outstanding are both strays.
        stray_d = rsp_hs & (gated | (cnt_q == '0));

        if (req_hs) begin
            burst_d = ~tile_req_last_i;
        end

        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (cnt_dec && !cnt_inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntWidth'(1);
        end

        unique case (state_q)
            ACTIVE: begin
                tmr_d = '0;
                if (isol_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                tmr_d = tmr_q + TmrWidth'(1);
                if (!isol_req_i) begin
                    state_d = ACTIVE;
                end else if ((cnt_q == '0) && !burst_q) begin
                    state_d = ISOLATED;
                end else if (tmr_q == TmrLast) begin
                    // Lost transactions are written off so the port restarts clean.
                    state_d = TIMEOUT;
                    cnt_d   = '0;
                    burst_d = 1'b0;
                end
            end
            default: begin
                if (!isol_req_i) begin
                    state_d = ACTIVE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ACTIVE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            burst_q   <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            burst_q   <= burst_d;
            ack_q     <= (state_d == ISOLATED) || (state_d == TIMEOUT);
            timeout_q <= (state_d == TIMEOUT);
            stray_q   <= stray_d;
        end
    end

    assign isol_ack_o    = ack_q;
    assign timeout_o     = timeout_q;
    assign stray_rsp_o   = stray_q;
    assign outstanding_o = cnt_q;

endmodule

// File: rtl/floo_tile_port_isolator.sv
// Purpose: NumPorts independent link isolation stages between tile router ports and mesh links.
// Latency: zero-cycle pass-through per port; status outputs registered.
// Backpressure: per-port gating only, no cross-port arbitration or coupling.
module floo_tile_port_isolator
    import floo_isol_pkg::*;
#(
    parameter int NumPorts       = 4,
    parameter int ReqWidth       = 64,
    parameter int RspWidth       = 64,
    parameter int MaxOutstanding = 16,
    parameter int DrainTimeout   = 1024,
    localparam int CntWidth      = cnt_width(MaxOutstanding)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumPorts-1:0]          isol_req_i,
    output logic [NumPorts-1:0]          isol_ack_o,
    output logic [NumPorts-1:0]          timeout_o,
    output logic [NumPorts-1:0]          stray_rsp_o,
    input  logic [NumPorts-1:0]          tile_req_valid_i,
    output logic [NumPorts-1:0]          tile_req_ready_o,
    input  logic [NumPorts-1:0]          tile_req_last_i,
    input  logic [NumPorts*ReqWidth-1:0] tile_req_data_i,
    output logic [NumPorts-1:0]          link_req_valid_o,
    input  logic [NumPorts-1:0]          link_req_ready_i,
    output logic [NumPorts-1:0]          link_req_last_o,
    output logic [NumPorts*ReqWidth-1:0] link_req_data_o,
    input  logic [NumPorts-1:0]          link_rsp_valid_i,
    output logic [NumPorts-1:0]          link_rsp_ready_o,
    input  logic [NumPorts*RspWidth-1:0] link_rsp_data_i,
    output logic [NumPorts-1:0]          tile_rsp_valid_o,
    input  logic [NumPorts-1:0]          tile_rsp_ready_i,
    output logic [NumPorts*RspWidth-1:0] tile_rsp_data_o,
    output logic [NumPorts*CntWidth-1:0] outstanding_o
);

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        floo_isol_port_ctrl #(
            .ReqWidth      (ReqWidth),
            .RspWidth      (RspWidth),
            .MaxOutstanding(MaxOutstanding),
            .DrainTimeout  (DrainTimeout)
        ) u_ctrl (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .isol_req_i      (isol_req_i[p]),
            .isol_ack_o      (isol_ack_o[p]),
            .timeout_o       (timeout_o[p]),
            .stray_rsp_o     (stray_rsp_o[p]),
            .tile_req_valid_i(tile_req_valid_i[p]),
            .tile_req_ready_o(tile_req_ready_o[p]),
            .tile_req_last_i (tile_req_last_i[p]),
            .tile_req_data_i (tile_req_data_i[p*ReqWidth +: ReqWidth]),
            .link_req_valid_o(link_req_valid_o[p]),
            .link_req_ready_i(link_req_ready_i[p]),
            .link_req_last_o (link_req_last_o[p]),
            .link_req_data_o (link_req_data_o[p*ReqWidth +: ReqWidth]),
            .link_rsp_valid_i(link_rsp_valid_i[p]),
            .link_rsp_ready_o(link_rsp_ready_o[p]),
            .link_rsp_data_i (link_rsp_data_i[p*RspWidth +: RspWidth]),
            .tile_rsp_valid_o(tile_rsp_valid_o[p]),
            .tile_rsp_ready_i(tile_rsp_ready_i[p]),
            .tile_rsp_data_o (tile_rsp_data_o[p*RspWidth +: RspWidth]),
            .outstanding_o   (outstanding_o[p*CntWidth +: CntWidth])
        );
    end

endmodule

// File: tb/tb_floo_tile_port_isolator.sv
// Bench for floo_tile_port_isolator: vector table, directed corner sequences, random traffic vs reference model.
module tb_floo_tile_port_isolator;

    localparam int NP   = 4;
    localparam int RW   = 16;
    localparam int SW   = 16;
    localparam int MAXO = 3;
    localparam int DT   = 8;
    localparam int CW   = 2;

    localparam int M_ACT = 0;
    localparam int M_DRN = 1;
    localparam int M_ISO = 2;
    localparam int M_TO  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [NP-1:0]     isol_req = '0, isol_ack, timeout, stray;
    logic [NP-1:0]     treq_v = '0, treq_r, treq_l = '0;
    logic [NP-1:0]     lreq_v, lreq_r = '0, lreq_l;
    logic [NP-1:0]     lrsp_v = '0, lrsp_r;
    logic [NP-1:0]     trsp_v, trsp_r = '0;
    logic [NP*RW-1:0]  treq_d = '0, lreq_d;
    logic [NP*SW-1:0]  lrsp_d = '0, trsp_d;
    logic [NP*CW-1:0]  outst;

    floo_tile_port_isolator #(
        .NumPorts(NP), .ReqWidth(RW), .RspWidth(SW),
        .MaxOutstanding(MAXO), .DrainTimeout(DT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .isol_req_i(isol_req), .isol_ack_o(isol_ack), .timeout_o(timeout), .stray_rsp_o(stray),
        .tile_req_valid_i(treq_v), .tile_req_ready_o(treq_r), .tile_req_last_i(treq_l),
        .tile_req_data_i(treq_d),
        .link_req_valid_o(lreq_v), .link_req_ready_i(lreq_r), .link_req_last_o(lreq_l),
        .link_req_data_o(lreq_d),
        .link_rsp_valid_i(lrsp_v), .link_rsp_ready_o(lrsp_r), .link_rsp_data_i(lrsp_d),
        .tile_rsp_valid_o(trsp_v), .tile_rsp_ready_i(trsp_r), .tile_rsp_data_o(trsp_d),
        .outstanding_o(outst)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: port mode, transaction count, drain time, open burst, registered status.
    int m_mode[NP];
    int m_cnt[NP];
    int m_tmr[NP];
    bit m_burst[NP];
    bit m_ack[NP];
    bit m_to[NP];
    bit m_stray[NP];

    typedef struct {
        int isol, tv, tl, lr, rv, trr;
        int e_cnt, e_rdy, e_ack;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int p, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s port %0d: got %0h expected %0h", name, p, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_mode[p] = M_ACT; m_cnt[p] = 0; m_tmr[p] = 0;
            m_burst[p] = 0; m_ack[p] = 0; m_to[p] = 0; m_stray[p] = 0;
        end
    endtask

    task automatic drive(input int p, input bit isol, input bit tv, input bit tl,
                         input bit lr, input bit rv, input bit trr);
        isol_req[p] = isol; treq_v[p] = tv; treq_l[p] = tl;
        lreq_r[p] = lr; lrsp_v[p] = rv; trsp_r[p] = trr;
    endtask

    task automatic sample();
        #2;
        for (int p = 0; p < NP; p++) begin
            bit gated, block;
            gated = (m_mode[p] == M_ISO) || (m_mode[p] == M_TO);
            block = gated || (!m_burst[p] && (m_mode[p] == M_DRN || m_cnt[p] == MAXO));
            chk("link_req_valid", p, lreq_v[p], treq_v[p] & !block);
            chk("tile_req_ready", p, treq_r[p], lreq_r[p] & !block);
            chk("link_req_last",  p, lreq_l[p], treq_l[p]);
            chk("tile_rsp_valid", p, trsp_v[p], lrsp_v[p] & !gated);
            chk("link_rsp_ready", p, lrsp_r[p], gated | trsp_r[p]);
            chk("isol_ack",       p, isol_ack[p], m_ack[p]);
            chk("timeout",        p, timeout[p], m_to[p]);
            chk("stray_rsp",      p, stray[p], m_stray[p]);
            chk("outstanding",    p, outst[p*CW +: CW], 64'(m_cnt[p]));
        end
        chk("req_data", -1, lreq_d, treq_d);
        chk("rsp_data", -1, trsp_d, lrsp_d);
    endtask

    task automatic advance();
        for (int p = 0; p < NP; p++) begin
            bit gated, block, req_hs, rsp_hs, inc, dec;
            int cnt0;
            bit burst0;
            gated  = (m_mode[p] == M_ISO) || (m_mode[p] == M_TO);
            block  = gated || (!m_burst[p] && (m_mode[p] == M_DRN || m_cnt[p] == MAXO));
            req_hs = treq_v[p] && lreq_r[p] && !block;
            rsp_hs = lrsp_v[p] && (gated || trsp_r[p]);
            inc    = req_hs && treq_l[p];
            dec    = rsp_hs && !gated;
            cnt0   = m_cnt[p];
            burst0 = m_burst[p];
            if (rst) begin
                m_mode[p] = M_ACT; m_cnt[p] = 0; m_tmr[p] = 0;
                m_burst[p] = 0; m_ack[p] = 0; m_to[p] = 0; m_stray[p] = 0;
            end else begin
                m_stray[p] = rsp_hs && (gated || cnt0 == 0);
                if (req_hs) m_burst[p] = !treq_l[p];
                if (inc && !dec) m_cnt[p] = cnt0 + 1;
                else if (dec && !inc && cnt0 > 0) m_cnt[p] = cnt0 - 1;
                case (m_mode[p])
                    M_ACT: begin
                        m_tmr[p] = 0;
                        if (isol_req[p]) m_mode[p] = M_DRN;
                    end
                    M_DRN: begin
                        if (!isol_req[p]) m_mode[p] = M_ACT;
                        else if (cnt0 == 0 && !burst0) m_mode[p] = M_ISO;
                        else if (m_tmr[p] == DT - 1) begin
                            m_mode[p] = M_TO; m_cnt[p] = 0; m_burst[p] = 0;
                        end
                        m_tmr[p] = m_tmr[p] + 1;
                    end
                    default: if (!isol_req[p]) m_mode[p] = M_ACT;
                endcase
                m_ack[p] = (m_mode[p] == M_ISO) || (m_mode[p] == M_TO);
                m_to[p]  = (m_mode[p] == M_TO);
            end
        end
        @(posedge clk);
        #1;
        treq_d = {$urandom, $urandom};
        lrsp_d = {$urandom, $urandom};
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) drive(p, 0, 0, 0, 1, 0, 1);
    endtask

    initial begin
        int rv_pct;
        // Port 0: fill to the limit, drain with responses; isol_ack never rises.
        tbl[0] = '{0, 1, 1, 1, 0, 0, 0, 1, 0};
        tbl[1] = '{0, 1, 1, 1, 0, 0, 1, 1, 0};
        tbl[2] = '{0, 1, 1, 1, 0, 0, 2, 1, 0};
        tbl[3] = '{0, 1, 1, 1, 0, 0, 3, 0, 0};
        tbl[4] = '{0, 1, 1, 1, 1, 1, 3, 0, 0};
        tbl[5] = '{0, 0, 0, 1, 1, 1, 2, 1, 0};
        tbl[6] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

        idle_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        sample();
        chk("reset_ack", -1, isol_ack, 0);
        chk("reset_outstanding", -1, outst, 0);
        advance();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(0, tbl[i].isol[0], tbl[i].tv[0], tbl[i].tl[0], tbl[i].lr[0],
                  tbl[i].rv[0], tbl[i].trr[0]);
            sample();
            chk("tbl_outstanding", 0, outst[CW-1:0], 64'(tbl[i].e_cnt));
            chk("tbl_req_ready",   0, treq_r[0], 64'(tbl[i].e_rdy));
            chk("tbl_isol_ack",    0, isol_ack[0], 64'(tbl[i].e_ack));
            advance();
        end
        idle_all();

        // Port 1: isolation raised mid-burst; the burst completes, then drain.
        drive(1, 0, 1, 0, 1, 0, 1); sample(); advance();
        drive(1, 0, 1, 0, 1, 0, 1); sample(); advance();
        drive(1, 1, 1, 0, 1, 0, 1); sample();
        chk("burst_flit3_pass", 1, lreq_v[1], 1); advance();
        drive(1, 1, 1, 1, 1, 0, 1); sample();
        chk("burst_flit4_pass", 1, treq_r[1], 1); advance();
        drive(1, 1, 1, 1, 1, 0, 1); sample();
        chk("drain_block_ready", 1, treq_r[1], 0);
        chk("drain_block_valid", 1, lreq_v[1], 0); advance();
        drive(1, 1, 0, 0, 1, 1, 1); sample();
        chk("drain_rsp_pass", 1, trsp_v[1], 1);
        chk("drain_ack_low", 1, isol_ack[1], 0); advance();
        drive(1, 1, 0, 0, 1, 0, 1); sample();
        chk("drain_ack_early", 1, isol_ack[1], 0); advance();
        sample();
        chk("drain_isol_ack", 1, isol_ack[1], 1);
        chk("drain_outstanding", 1, outst[1*CW +: CW], 0); advance();
        drive(1, 0, 0, 0, 1, 0, 1); sample(); advance();
        sample();
        chk("release_ack", 1, isol_ack[1], 0); advance();

        // Port 2: one lost transaction, drain runs out of time.
        drive(2, 0, 1, 1, 1, 0, 1); sample(); advance();
        drive(2, 1, 0, 0, 1, 0, 1); sample(); advance();
        for (int i = 0; i < DT; i++) begin
            sample();
            chk("timeout_early", 2, timeout[2], 0);
            advance();
        end
        sample();
        chk("timeout_set", 2, timeout[2], 1);
        chk("timeout_ack", 2, isol_ack[2], 1);
        chk("timeout_cnt_clear", 2, outst[2*CW +: CW], 0); advance();
        drive(2, 0, 0, 0, 1, 0, 1); sample(); advance();
        sample();
        chk("timeout_release", 2, timeout[2], 0);
        chk("timeout_release_ack", 2, isol_ack[2], 0);
        chk("timeout_release_rdy", 2, treq_r[2], 1); advance();

        // Port 3: isolated port swallows a stray response.
        drive(3, 1, 0, 0, 1, 0, 1); sample(); advance();
        sample(); advance();
        drive(3, 1, 0, 0, 1, 1, 0); sample();
        chk("iso_ack", 3, isol_ack[3], 1);
        chk("iso_rsp_ready", 3, lrsp_r[3], 1);
        chk("iso_rsp_valid", 3, trsp_v[3], 0);
        chk("iso_stray_pre", 3, stray[3], 0); advance();
        drive(3, 1, 0, 0, 1, 0, 1); sample();
        chk("iso_stray_pulse", 3, stray[3], 1); advance();
        drive(3, 0, 0, 0, 1, 0, 1); sample();
        chk("iso_stray_once", 3, stray[3], 0); advance();
        sample(); advance();

        // All ports: reset while draining.
        for (int p = 0; p < NP; p++) drive(p, 0, 1, 1, 1, 0, 1);
        sample(); advance();
        for (int p = 0; p < NP; p++) drive(p, 1, 0, 0, 1, 0, 1);
        sample(); advance();
        sample(); advance();
        rst = 1'b1;
        sample(); advance();
        rst = 1'b0;
        idle_all();
        sample();
        chk("rst_drain_ack", -1, isol_ack, 0);
        chk("rst_drain_timeout", -1, timeout, 0);
        chk("rst_drain_stray", -1, stray, 0);
        chk("rst_drain_outstanding", -1, outst, 0);
        chk("rst_drain_ready", -1, treq_r, 4'hf);
        advance();

        // Random traffic against the reference model.
        rv_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom % 3)
                    0: rv_pct = 0;
                    1: rv_pct = 15;
                    default: rv_pct = 60;
                endcase
            end
            rst = (($urandom % 500) == 0);
            for (int p = 0; p < NP; p++) begin
                if (($urandom % 24) == 0) isol_req[p] = !isol_req[p];
                treq_v[p] = (($urandom % 2) == 1);
                treq_l[p] = (($urandom % 3) != 0);
                lreq_r[p] = (($urandom % 4) != 0);
                lrsp_v[p] = (($urandom % 100) < rv_pct);
                trsp_r[p] = (($urandom % 4) != 0);
            end
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
